// File: rtl/usart_fifo_pkg.sv
// Shared constants and helpers for the generic USART FIFO (usart_fifo_gen).
// Build option: define USART_FIFO_OVR_EN to include the sticky overrun flag.
package usart_fifo_pkg;

  function automatic int fn_clog2(input int value);
    int r;
    r = 0;
    for (int v = 1; v < value; v = v * 2) r++;
    return r;
  endfunction

  // Width needed to hold 0..depth inclusive.
  function automatic int fn_cw(input int depth);
    return fn_clog2(depth + 1);
  endfunction

  // Index width, never narrower than one bit so DEPTH=1 still has a legal vector.
  function automatic int fn_iw(input int depth);
    return (fn_clog2(depth) < 1) ? 1 : fn_clog2(depth);
  endfunction

  localparam int RX_DEPTH = 3;
  localparam int RX_WIDTH = 9;
  localparam int RX_CW    = fn_cw(RX_DEPTH);
  localparam int TX_DEPTH = 2;
  localparam int TX_WIDTH = 9;
  localparam int TX_CW    = fn_cw(TX_DEPTH);

endpackage

// File: rtl/usart_fifo_gen_if.sv
// Bus between a USART shift register / UDR side and one usart_fifo_gen instance.
// Build option: ovr/ovr_clr are only meaningful with USART_FIFO_OVR_EN defined.
interface usart_fifo_gen_if #(
  parameter int WIDTH = 9,
  parameter int CW    = 2
);
  // Handshake: a write is taken on a clock edge where we=1 and the FIFO is not
  // full (or a read is taken in the same cycle); a read is taken where re=1 and
  // the FIFO is not empty. Requests that are not taken are simply dropped.
  logic             flush;
  logic [WIDTH-1:0] din;
  logic             we;
  logic             re;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             ovr;
  logic             ovr_clr;

  modport master (
    output flush, din, we, re, ovr_clr,
    input  dout, full, empty, almost_full, almost_empty, count, ovr
  );

  modport slave (
    input  flush, din, we, re, ovr_clr,
    output dout, full, empty, almost_full, almost_empty, count, ovr
  );
endinterface

// File: rtl/usart_fifo_ctrl.sv
// Memory-free index, occupancy and status logic for usart_fifo_gen.
// Build option: none here; USART_FIFO_OVR_EN is handled in the top.
module usart_fifo_ctrl
  import usart_fifo_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 0,
  localparam int CW      = fn_cw(DEPTH),
  localparam int IW      = fn_iw(DEPTH)
) (
  input  logic          cp2,
  input  logic          ireset,
  input  logic          flush,
  input  logic          we,
  input  logic          re,
  output logic          we_ok,
  output logic          re_ok,
  output logic [IW-1:0] wr_idx,
  output logic [IW-1:0] rd_idx,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty
);

  // Wrap at DEPTH-1 explicitly so non power-of-two depths work.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(DEPTH - 1)) ? '0 : idx + IW'(1);
  endfunction

  always_comb begin
    full         = (count == CW'(DEPTH));
    empty        = (count == '0);
    almost_full  = (count >= CW'(AF_LEVEL));
    almost_empty = (count <= CW'(AE_LEVEL));
    re_ok        = re & ~empty;
    we_ok        = we & (~full | re_ok);
  end

  always_ff @(posedge cp2) begin
    if (ireset || flush) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (we_ok) wr_idx <= next_idx(wr_idx);
      if (re_ok) rd_idx <= next_idx(rd_idx);
      case ({we_ok, re_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/usart_fifo_gen.sv
// Generic-depth show-ahead FIFO for one USART direction (storage + output stage).
// Build option: define USART_FIFO_OVR_EN to synthesise the sticky overrun flag.
module usart_fifo_gen
  import usart_fifo_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int WIDTH    = 9,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 0,
  parameter int SYNC_OUT = 0
) (
  input  logic           cp2,
  input  logic           ireset,
  usart_fifo_gen_if.slave bus
);

  localparam int CW = fn_cw(DEPTH);
  localparam int IW = fn_iw(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             we_ok, re_ok;
  logic [IW-1:0]    wr_idx, rd_idx;
  logic [CW-1:0]    count;
  logic             full, empty, almost_full, almost_empty;
  logic [WIDTH-1:0] dout_int;
  logic             ovr_int;

  usart_fifo_ctrl #(
    .DEPTH   (DEPTH),
    .AF_LEVEL(AF_LEVEL),
    .AE_LEVEL(AE_LEVEL)
  ) u_ctrl (
    .cp2         (cp2),
    .ireset      (ireset),
    .flush       (bus.flush),
    .we          (bus.we),
    .re          (bus.re),
    .we_ok       (we_ok),
    .re_ok       (re_ok),
    .wr_idx      (wr_idx),
    .rd_idx      (rd_idx),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty)
  );

  always_ff @(posedge cp2) begin
    if (we_ok) mem[wr_idx] <= bus.din;
  end

  // Memory is never reset, so dout reads as zero while nothing is stored.
  assign dout_int = empty ? '0 : mem[rd_idx];

`ifdef USART_FIFO_OVR_EN
  logic ovr_q;
  always_ff @(posedge cp2) begin
    if (ireset)                ovr_q <= 1'b0;
    else if (bus.we && !we_ok) ovr_q <= 1'b1;
    else if (bus.ovr_clr)      ovr_q <= 1'b0;
  end
  assign ovr_int = ovr_q;
`else
  logic unused_ovr_clr;
  assign unused_ovr_clr = bus.ovr_clr;
  assign ovr_int        = 1'b0;
`endif

  assign bus.count = count;

  generate
    if (SYNC_OUT != 0) begin : g_sync
      logic [WIDTH-1:0] dout_q;
      logic             full_q, empty_q, af_q, ae_q, ovr_q2;
      always_ff @(posedge cp2) begin
        if (ireset) begin
          dout_q  <= '0;
          full_q  <= 1'b0;
          empty_q <= 1'b1;
          af_q    <= 1'b0;
          ae_q    <= 1'b1;
          ovr_q2  <= 1'b0;
        end else begin
          dout_q  <= dout_int;
          full_q  <= full;
          empty_q <= empty;
          af_q    <= almost_full;
          ae_q    <= almost_empty;
          ovr_q2  <= ovr_int;
        end
      end
      assign bus.dout         = dout_q;
      assign bus.full         = full_q;
      assign bus.empty        = empty_q;
      assign bus.almost_full  = af_q;
      assign bus.almost_empty = ae_q;
      assign bus.ovr          = ovr_q2;
    end else begin : g_comb
      assign bus.dout         = dout_int;
      assign bus.full         = full;
      assign bus.empty        = empty;
      assign bus.almost_full  = almost_full;
      assign bus.almost_empty = almost_empty;
      assign bus.ovr          = ovr_int;
    end
  endgenerate

endmodule

// File: tb/tb_usart_fifo_gen.sv
// Self-checking bench for usart_fifo_gen: DEPTH=3, DEPTH=5 thresholds, SYNC_OUT=1.
// Build option: define USART_FIFO_OVR_EN to expect the overrun flag to work.
module tb_usart_fifo_gen;

  logic cp2 = 1'b0;
  logic ireset = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [8:0] exp_q[$];
  logic [8:0] q5[$];
  logic [8:0] got;

`ifdef USART_FIFO_OVR_EN
  localparam logic OVR_ON = 1'b1;
`else
  localparam logic OVR_ON = 1'b0;
`endif

  always #5 cp2 = ~cp2;

  usart_fifo_gen_if #(.WIDTH(9), .CW(2)) if_d3 ();
  usart_fifo_gen_if #(.WIDTH(9), .CW(3)) if_d5 ();
  usart_fifo_gen_if #(.WIDTH(9), .CW(2)) if_s3 ();

  usart_fifo_gen #(.DEPTH(3), .WIDTH(9)) u_d3 (.cp2(cp2), .ireset(ireset), .bus(if_d3));
  usart_fifo_gen #(.DEPTH(5), .WIDTH(9), .AF_LEVEL(4), .AE_LEVEL(1)) u_d5 (
    .cp2(cp2), .ireset(ireset), .bus(if_d5));
  usart_fifo_gen #(.DEPTH(3), .WIDTH(9), .SYNC_OUT(1)) u_s3 (.cp2(cp2), .ireset(ireset), .bus(if_s3));

  task automatic tick;
    @(posedge cp2);
    #1;
  endtask

  task automatic idle_all;
    if_d3.flush = 0; if_d3.we = 0; if_d3.re = 0; if_d3.ovr_clr = 0; if_d3.din = '0;
    if_d5.flush = 0; if_d5.we = 0; if_d5.re = 0; if_d5.ovr_clr = 0; if_d5.din = '0;
    if_s3.flush = 0; if_s3.we = 0; if_s3.re = 0; if_s3.ovr_clr = 0; if_s3.din = '0;
  endtask

  task automatic d3_push(input logic [8:0] d);
    if_d3.din = d; if_d3.we = 1; exp_q.push_back(d);
    tick;
    if_d3.we = 0;
  endtask

  task automatic d3_pulse_re;
    if_d3.re = 1;
    tick;
    if_d3.re = 0;
  endtask

  task automatic test_reset;
    idle_all();
    ireset = 1;
    tick; tick;
    n_cmp++;
    if ({if_d3.full, if_d3.empty, if_d3.almost_full, if_d3.almost_empty, if_d3.count, if_d3.dout} !==
        {4'b0101, 2'd0, 9'd0}) begin
      n_fail++;
      $display("FAIL reset_d3 status=%b count=%0d dout=%h want status=0101 count=0 dout=000",
               {if_d3.full, if_d3.empty, if_d3.almost_full, if_d3.almost_empty}, if_d3.count, if_d3.dout);
    end
    n_cmp++;
    if (if_d3.ovr !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got=%b want=0", if_d3.ovr); end
    n_cmp++;
    if ({if_s3.full, if_s3.empty, if_s3.almost_full, if_s3.almost_empty, if_s3.dout} !== {4'b0101, 9'd0}) begin
      n_fail++;
      $display("FAIL reset_s3 status=%b dout=%h want 0101/000",
               {if_s3.full, if_s3.empty, if_s3.almost_full, if_s3.almost_empty}, if_s3.dout);
    end
    ireset = 0;
    exp_q.delete();
    q5.delete();
    tick;
  endtask

  task automatic test_fill_drain;
    d3_push(9'h101);
    n_cmp++;
    if (if_d3.count !== 2'd1 || if_d3.dout !== 9'h101) begin
      n_fail++; $display("FAIL first_write count=%0d dout=%h want 1/101", if_d3.count, if_d3.dout);
    end
    d3_push(9'h055);
    d3_push(9'h0AA);
    n_cmp++;
    if (if_d3.count !== 2'd3 || {if_d3.full, if_d3.empty, if_d3.almost_full, if_d3.almost_empty} !== 4'b1010) begin
      n_fail++;
      $display("FAIL full3 count=%0d status=%b want 3/1010", if_d3.count,
               {if_d3.full, if_d3.empty, if_d3.almost_full, if_d3.almost_empty});
    end
    for (int i = 0; i < 3; i++) begin
      got = exp_q.pop_front();
      n_cmp++;
      if (if_d3.dout !== got) begin n_fail++; $display("FAIL drain_dout got=%h want=%h", if_d3.dout, got); end
      d3_pulse_re();
    end
    n_cmp++;
    if (if_d3.count !== 2'd0 || {if_d3.full, if_d3.empty, if_d3.almost_full, if_d3.almost_empty} !== 4'b0101 ||
        if_d3.dout !== 9'h000) begin
      n_fail++; $display("FAIL drained count=%0d empty=%b dout=%h want 0/1/000", if_d3.count, if_d3.empty, if_d3.dout);
    end
  endtask

  task automatic test_pass_through;
    d3_push(9'h011); d3_push(9'h022); d3_push(9'h033);
    got = exp_q.pop_front();
    n_cmp++;
    if (if_d3.dout !== got) begin n_fail++; $display("FAIL pt_head got=%h want=%h", if_d3.dout, got); end
    if_d3.din = 9'h1FF; if_d3.we = 1; if_d3.re = 1; exp_q.push_back(9'h1FF);
    tick;
    if_d3.we = 0; if_d3.re = 0;
    n_cmp++;
    if (if_d3.count !== 2'd3 || if_d3.full !== 1'b1 || if_d3.dout !== exp_q[0]) begin
      n_fail++; $display("FAIL pt_full count=%0d full=%b dout=%h want 3/1/%h", if_d3.count, if_d3.full, if_d3.dout, exp_q[0]);
    end
    for (int i = 0; i < 3; i++) begin
      got = exp_q.pop_front();
      n_cmp++;
      if (if_d3.dout !== got) begin n_fail++; $display("FAIL pt_drain got=%h want=%h", if_d3.dout, got); end
      d3_pulse_re();
    end
    n_cmp++;
    if (if_d3.empty !== 1'b1) begin n_fail++; $display("FAIL pt_empty got=%b want=1", if_d3.empty); end
  endtask

  task automatic test_overrun;
    d3_push(9'h0A1); d3_push(9'h0A2); d3_push(9'h0A3);
    if_d3.din = 9'h033; if_d3.we = 1;
    tick;
    if_d3.we = 0;
    n_cmp++;
    if (if_d3.count !== 2'd3 || if_d3.ovr !== OVR_ON) begin
      n_fail++; $display("FAIL ovr_set count=%0d ovr=%b want 3/%b", if_d3.count, if_d3.ovr, OVR_ON);
    end
    if_d3.ovr_clr = 1;
    tick;
    if_d3.ovr_clr = 0;
    n_cmp++;
    if (if_d3.ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clr got=%b want=0", if_d3.ovr); end
    if_d3.din = 9'h034; if_d3.we = 1; if_d3.ovr_clr = 1;
    tick;
    if_d3.we = 0; if_d3.ovr_clr = 0;
    n_cmp++;
    if (if_d3.ovr !== OVR_ON) begin n_fail++; $display("FAIL ovr_set_wins got=%b want=%b", if_d3.ovr, OVR_ON); end
    if_d3.ovr_clr = 1;
    tick;
    if_d3.ovr_clr = 0;
    for (int i = 0; i < 3; i++) begin
      got = exp_q.pop_front();
      n_cmp++;
      if (if_d3.dout !== got) begin n_fail++; $display("FAIL ovr_drain got=%h want=%h", if_d3.dout, got); end
      d3_pulse_re();
    end
    n_cmp++;
    if (if_d3.empty !== 1'b1 || if_d3.ovr !== 1'b0) begin
      n_fail++; $display("FAIL ovr_end empty=%b ovr=%b want 1/0", if_d3.empty, if_d3.ovr);
    end
  endtask

  task automatic test_thresholds;
    logic [8:0] d;
    for (int k = 0; k <= 5; k++) begin
      n_cmp++;
      if (if_d5.count !== 3'(k) || if_d5.almost_empty !== (k <= 1) || if_d5.almost_full !== (k >= 4) ||
          if_d5.full !== (k == 5) || if_d5.empty !== (k == 0)) begin
        n_fail++;
        $display("FAIL thr_k%0d count=%0d ae=%b af=%b full=%b empty=%b", k, if_d5.count,
                 if_d5.almost_empty, if_d5.almost_full, if_d5.full, if_d5.empty);
      end
      if (k < 5) begin
        d = 9'($urandom_range(0, 511));
        if_d5.din = d; if_d5.we = 1; q5.push_back(d);
        tick;
        if_d5.we = 0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      got = q5.pop_front();
      n_cmp++;
      if (if_d5.dout !== got) begin n_fail++; $display("FAIL d5_drain got=%h want=%h", if_d5.dout, got); end
      if_d5.re = 1; tick; if_d5.re = 0;
    end
    for (int i = 0; i < 10; i++) begin
      d = 9'($urandom_range(0, 511));
      got = q5.pop_front();
      q5.push_back(d);
      n_cmp++;
      if (if_d5.dout !== got) begin n_fail++; $display("FAIL d5_wrap%0d got=%h want=%h", i, if_d5.dout, got); end
      if_d5.din = d; if_d5.we = 1; if_d5.re = 1;
      tick;
      if_d5.we = 0; if_d5.re = 0;
      n_cmp++;
      if (if_d5.count !== 3'd2) begin n_fail++; $display("FAIL d5_wrap_count got=%0d want=2", if_d5.count); end
    end
    while (q5.size() > 0) begin
      got = q5.pop_front();
      n_cmp++;
      if (if_d5.dout !== got) begin n_fail++; $display("FAIL d5_tail got=%h want=%h", if_d5.dout, got); end
      if_d5.re = 1; tick; if_d5.re = 0;
    end
  endtask

  task automatic test_empty_we_re;
    if_d3.din = 9'h042; if_d3.we = 1; if_d3.re = 1; exp_q.push_back(9'h042);
    tick;
    if_d3.we = 0; if_d3.re = 0;
    n_cmp++;
    if (if_d3.count !== 2'd1 || if_d3.dout !== exp_q[0]) begin
      n_fail++; $display("FAIL empty_wr count=%0d dout=%h want 1/%h", if_d3.count, if_d3.dout, exp_q[0]);
    end
    if_d3.flush = 1; if_d3.we = 1; if_d3.din = 9'h077;
    tick;
    if_d3.flush = 0; if_d3.we = 0;
    exp_q.delete();
    n_cmp++;
    if (if_d3.count !== 2'd0 || if_d3.empty !== 1'b1) begin
      n_fail++; $display("FAIL flush count=%0d empty=%b want 0/1", if_d3.count, if_d3.empty);
    end
    d3_push(9'h0BB);
    got = exp_q.pop_front();
    n_cmp++;
    if (if_d3.dout !== got || if_d3.count !== 2'd1) begin
      n_fail++; $display("FAIL post_flush dout=%h count=%0d want %h/1", if_d3.dout, if_d3.count, got);
    end
    d3_pulse_re();
  endtask

  task automatic test_sync_out;
    ireset = 1; tick; ireset = 0;
    exp_q.delete();
    if_d3.din = 9'h1C3; if_d3.we = 1;
    if_s3.din = 9'h1C3; if_s3.we = 1;
    tick;
    if_d3.we = 0; if_s3.we = 0;
    n_cmp++;
    if (if_d3.empty !== 1'b0 || if_s3.empty !== 1'b1 || if_s3.count !== 2'd1) begin
      n_fail++; $display("FAIL sync_lag d3_empty=%b s3_empty=%b s3_count=%0d want 0/1/1",
                         if_d3.empty, if_s3.empty, if_s3.count);
    end
    tick;
    n_cmp++;
    if (if_s3.empty !== 1'b0 || if_s3.dout !== 9'h1C3) begin
      n_fail++; $display("FAIL sync_out empty=%b dout=%h want 0/1c3", if_s3.empty, if_s3.dout);
    end
    if_s3.din = 9'h0D1; if_s3.we = 1;
    tick;
    if_s3.din = 9'h0D2; ireset = 1;
    tick;
    if_s3.we = 0; ireset = 0;
    n_cmp++;
    if (if_s3.count !== 2'd0 || if_s3.empty !== 1'b1 || if_s3.dout !== 9'h000 || if_d3.count !== 2'd0) begin
      n_fail++; $display("FAIL sync_reset count=%0d empty=%b dout=%h d3_count=%0d want 0/1/000/0",
                         if_s3.count, if_s3.empty, if_s3.dout, if_d3.count);
    end
  endtask

  task automatic test_back_to_back;
    int cnt;
    logic w, r, wok, rok;
    logic [8:0] d;
    cnt = 0;
    exp_q.delete();
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = 9'($urandom_range(0, 511));
      rok = r && (cnt > 0);
      wok = w && ((cnt < 3) || rok);
      if (rok) begin
        got = exp_q.pop_front();
        n_cmp++;
        if (if_d3.dout !== got) begin n_fail++; $display("FAIL b2b_dout%0d got=%h want=%h", i, if_d3.dout, got); end
      end
      if (wok) exp_q.push_back(d);
      if_d3.din = d; if_d3.we = w; if_d3.re = r;
      tick;
      cnt = cnt + int'(wok) - int'(rok);
      n_cmp++;
      if (if_d3.count !== 2'(cnt) || if_d3.full !== (cnt == 3)) begin
        n_fail++; $display("FAIL b2b_count%0d got=%0d/%b want=%0d", i, if_d3.count, if_d3.full, cnt);
      end
    end
    if_d3.we = 0; if_d3.re = 0;
  endtask

  initial begin
    idle_all();
    test_reset();
    test_fill_drain();
    test_pass_through();
    test_overrun();
    test_thresholds();
    test_empty_we_re();
    test_sync_out();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/usart_fifo_gen.md
Name: usart_fifo_gen

Overview:
Parametrised successor to the two-entry USART receive/transmit buffer. Supports arbitrary depth (not restricted to powers of two), arbitrary width, an occupancy count, and programmable almost-full/almost-empty thresholds. Sits between the USART shift registers and the UDR register interface, one instance per direction.

Parameters:
DEPTH, 2, number of entries; legal range 1..256.
WIDTH, 9, data bits per entry (9 covers USART 9-bit frames).
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
AE_LEVEL, 0, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.
SYNC_OUT, 0, 1 = dout and all status outputs registered one extra cycle.

Ports:
cp2  in  1  system clock; all logic on its rising edge.
ireset  in  1  synchronous, active-high reset.
flush  in  1  synchronous clear of contents, pointers and count.
din  in  WIDTH  write data.
we  in  1  write request.
re  in  1  read request; pops the entry currently on dout.
dout  out  WIDTH  head entry (show-ahead).
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AF_LEVEL.
almost_empty  out  1  count <= AE_LEVEL.
count  out  CW  occupancy, CW = clog2(DEPTH+1).
ovr  out  1  sticky overrun flag (optional feature).
ovr_clr  in  1  clears ovr (optional feature).

Behaviour:
- Storage: DEPTH x WIDTH registers. Write index wr_idx and read index rd_idx each span 0..DEPTH-1 and wrap from DEPTH-1 to 0; no power-of-two assumption. count is a separate CW-bit register.
- Reset (ireset=1 at the edge): wr_idx=0, rd_idx=0, count=0. Memory contents are not reset. Output values: dout=0, empty=1, full=0, almost_empty=1, almost_full=0, ovr=0. ireset has priority over flush, we and re.
- flush: same effect as reset on wr_idx, rd_idx and count; ovr is unaffected. flush has priority over we and re in the same cycle.
- we_ok = we & (~full | re_ok); re_ok = re & ~empty.
  - A write is accepted when full only if a read is accepted in the same cycle (pass-through).
  - A read when empty is ignored; a same-cycle write is still accepted.
- Count update: count += we_ok - re_ok. count is never below 0 and never above DEPTH.
- Show-ahead output with SYNC_OUT=0:
  - dout = mem[rd_idx], combinational from registers.
  - A write into an empty FIFO is visible on dout in the cycle after the write edge.
  - Status outputs are combinational decodes of count.
- SYNC_OUT=1: dout, full, empty, almost_full and almost_empty are each delayed by one register stage. The reset values listed above apply to these registers. Handshake qualification (we_ok/re_ok) always uses the internal unregistered status.
- DEPTH=1: indices are constant 0; full = (count==1).
- Simultaneous we and re at 0 < count < DEPTH: both accepted; count unchanged; both indices advance.

Optional Feature:
Macro USART_FIFO_OVR_EN.
- Defined:
  - ovr sets on any cycle with we=1 & ~we_ok, i.e. a write dropped while full.
  - ovr clears on ovr_clr=1. Set wins over a simultaneous clear.
  - ovr resets to 0 on ireset.
  - ovr follows the SYNC_OUT registering.
  - This is the source of the USART DOR bit.
- Not defined: ovr is tied to 0, ovr_clr is ignored, and no overrun register is synthesised.

Decomposition:
- Package usart_fifo_pkg holds:
  - the fn_clog2 constant function;
  - CW derivation;
  - default depth/width constants for the RX instance (DEPTH 3, WIDTH 9, matching ATmega UDR0 buffering) and the TX instance (DEPTH 2, WIDTH 9).
- One sub-module, usart_fifo_ctrl, contains index/count/status logic and we_ok/re_ok. It is memory-free so it can be verified standalone.
- Storage array and output muxing live in usart_fifo_gen.

Test Plan:
- DEPTH=3, WIDTH=9: reset, write 0x101, 0x055, 0x0AA -> full=1, count=3. Read three times -> dout sequence 0x101, 0x055, 0x0AA, then empty=1.
- DEPTH=3, full: assert we and re together with din=0x1FF -> count stays 3; dout advances; 0x1FF is read last after two more pops.
- DEPTH=3, full: write 0x033 without re, with USART_FIFO_OVR_EN -> ovr=1, data dropped, count=3. Pulse ovr_clr -> ovr=0.
- DEPTH=5, AF_LEVEL=4, AE_LEVEL=1: fill 0->5 entries -> almost_empty high at count 0..1, almost_full high at 4..5. Indices wrap correctly across ten write/read pairs.
- Empty FIFO: we and re together with 0x042 -> read ignored, count=1, dout=0x042 the next cycle. Then assert flush together with we -> count=0, empty=1.
- SYNC_OUT=1: single write -> empty deasserts one cycle later than with SYNC_OUT=0. ireset mid-fill -> count=0 and empty=1 after the reset edge.
